axis_perf_monitor: RTL and testbench
====================================

# axis_perf_monitor

Passive, multi-channel AXI-Stream performance monitor for the XDMA/UDP loopback test path. It taps NUM_CH streams, such as XDMA H2C/C2H and UDP TX/RX, without driving any handshake signal. For each channel it counts cycles, beats, packets and bytes between the first observed frame and a stop condition. It extends the current single-direction TX/RX counters with:
- a configurable channel count and width;
- byte accounting from tkeep;
- a target-packet auto-stop;
- saturation with a sticky overflow flag.

## Interface
Parameters:
- NUM_CH, default 2: number of monitored streams.
- KEEP_WIDTH, default 64: tkeep bits per channel, one per byte (512-bit data).
- CNT_WIDTH, default 32: width of the cycle, beat and packet counters and of target_pkt_num.
- BYTE_CNT_WIDTH, default 40: width of the byte counter.

Ports:
- CLK  in  1  monitor clock; all logic is in this single domain.
- RST_N  in  1  reset, asynchronous, active-low.
- mon_tvalid  in  NUM_CH  tapped tvalid, one bit per channel.
- mon_tready  in  NUM_CH  tapped tready.
- mon_tlast  in  NUM_CH  tapped tlast.
- mon_tkeep  in  NUM_CH*KEEP_WIDTH  tapped tkeep; channel i occupies bits [i*KEEP_WIDTH +: KEEP_WIDTH].
- start  in  1  single-cycle pulse: clear all channels and arm them.
- stop  in  1  single-cycle pulse: force every ARMED or RUN channel to DONE.
- target_pkt_num  in  CNT_WIDTH  packets per run, latched at start; 0 selects free-run.
- ch_state  out  NUM_CH*2  per-channel state code.
- first_frame  out  NUM_CH  sticky; set on a channel's first beat after start.
- cycle_cnt  out  NUM_CH*CNT_WIDTH  per-channel active-cycle counter.
- beat_cnt  out  NUM_CH*CNT_WIDTH  per-channel beat counter.
- pkt_cnt  out  NUM_CH*CNT_WIDTH  per-channel packet counter.
- byte_cnt  out  NUM_CH*BYTE_CNT_WIDTH  per-channel byte counter.
- overflow  out  NUM_CH  sticky; set when any counter of that channel saturates.
- all_done  out  1  high when every channel is in DONE.

## Operation
- A beat on channel i is a cycle with mon_tvalid[i] & mon_tready[i].
- Each channel has its own state machine:
  - IDLE=0: counters hold. start → ARMED.
  - ARMED=1: counters are zero. The first beat → RUN, with cycle_cnt=1 and that beat counted. stop → DONE with counters left at zero.
  - RUN=2: each cycle, cycle_cnt += 1. On each beat, beat_cnt += 1 and byte_cnt += popcount(tkeep). On a beat with tlast, pkt_cnt += 1. The channel goes → DONE on stop, or, when the latched target ≠ 0, on the beat that makes pkt_cnt equal the target; that beat and cycle are counted.
  - DONE=3: all counters freeze and further traffic is ignored. start → ARMED.
- start in any state clears every counter, first_frame and overflow, latches target_pkt_num, and moves the channel to ARMED.
- start and stop in the same cycle: start wins.
- Each counter saturates at all-ones and never wraps; the first saturating increment sets overflow[i].
- tkeep is counted by popcount. Non-contiguous tkeep is counted as given, with no error.
- Monitor outputs never influence the tapped streams.

## Timing
- Reset (RST_N low, asynchronous): every state resets to IDLE; all counters, first_frame and overflow reset to 0; the latched target resets to 0; all_done reset value is 0.
- Deassertion of RST_N is assumed synchronised externally to CLK.
- A beat in cycle t is visible in the counters and first_frame at t+1.
- A stop pulse or the target beat in cycle t makes ch_state read DONE at t+1.
- A start in cycle t makes ch_state read ARMED and counters read zero at t+1. A beat in cycle t on an ARMED channel is counted; a beat in the start cycle itself is not.
- all_done is combinational from the state registers, so it rises in the same cycle the last channel reads DONE.
- cycle_cnt is the number of cycles from the first beat up to and including the stopping cycle.
- Reset asserted mid-run clears everything immediately; there is no resume.

## Structure
- Shared package axis_perf_pkg holds:
  - the state typedef with its codes (IDLE, ARMED, RUN, DONE);
  - the default width constants;
  - a parametrised popcount function.
- Sub-module axis_perf_channel holds one channel's state machine, its counters and its saturation logic. It is instantiated NUM_CH times by a generate loop.
- The top level holds the target latch, start/stop fan-out, output packing and the all_done reduction.

## Test plan
- Reset: hold RST_N low mid-stream → all outputs 0, ch_state=IDLE on every channel; release → outputs stay 0 until start.
- Target stop: NUM_CH=1, target=4, four 3-beat packets, tkeep all-ones on the first two beats and 0x000F on the last → pkt_cnt=4, beat_cnt=12, byte_cnt=528, DONE; a fifth packet leaves the counters unchanged.
- Backpressure and free-run: target=0, tvalid held high, tready toggling every cycle for 20 cycles, then stop → beat_cnt=10, cycle_cnt equals the cycles from the first beat through the stop cycle, DONE.
- Saturation: CNT_WIDTH=8, 300 beats with no tlast → beat_cnt=255, overflow=1, pkt_cnt=0.
- Multi-channel: NUM_CH=2, target=2, channel 0 completes and channel 1 completes 5 cycles later → all_done rises only in the cycle channel 1 reads DONE; start and stop in the same cycle → both channels ARMED with counters 0.
- Restart: start while in RUN with counters nonzero → next cycle ARMED, all counters 0, overflow and first_frame cleared.

Source files
------------

// File: rtl/axis_perf_pkg.sv
// axis_perf_pkg: channel state codes, default widths and a
// popcount helper shared by the AXI-Stream performance monitor.
package axis_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } ch_state_e;

  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_KEEP_WIDTH     = 64;
  localparam int DEF_CNT_WIDTH      = 32;
  localparam int DEF_BYTE_CNT_WIDTH = 40;

  // Widest tkeep the helper accepts; callers zero-extend into it.
  localparam int POP_MAX = 256;
  localparam int POP_W   = $clog2(POP_MAX + 1);

  function automatic logic [POP_W-1:0] popcount(
    input logic [POP_MAX-1:0] v
  );
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      cnt = cnt + POP_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axis_perf_channel.sv
// axis_perf_channel: one tapped stream's IDLE/ARMED/RUN/DONE FSM
// with saturating cycle, beat, packet and byte counters.
// Ports: CLK, RST_N, tvalid/tready/tlast/tkeep tap, start/stop,
// latched target; state, first_frame, counters, overflow out.
module axis_perf_channel
  import axis_perf_pkg::*;
#(
  parameter int KEEP_WIDTH     = DEF_KEEP_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int BYTE_CNT_WIDTH = DEF_BYTE_CNT_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      tvalid,
  input  logic                      tready,
  input  logic                      tlast,
  input  logic [KEEP_WIDTH-1:0]     tkeep,
  input  logic                      start,
  input  logic                      stop,
  input  logic [CNT_WIDTH-1:0]      target,
  output logic [1:0]                state,
  output logic                      first_frame,
  output logic [CNT_WIDTH-1:0]      cycle_cnt,
  output logic [CNT_WIDTH-1:0]      beat_cnt,
  output logic [CNT_WIDTH-1:0]      pkt_cnt,
  output logic [BYTE_CNT_WIDTH-1:0] byte_cnt,
  output logic                      overflow
);

  ch_state_e state_q, state_d;

  logic beat, hit, cnt_en, clr, ovf;
  logic [POP_MAX-1:0]        keep_ext;
  logic [POP_W-1:0]          pop;
  logic [CNT_WIDTH:0]        cyc_sum, beat_sum, pkt_sum;
  logic [BYTE_CNT_WIDTH:0]   byte_sum;
  logic [CNT_WIDTH-1:0]      cyc_nx, beat_nx, pkt_nx;
  logic [BYTE_CNT_WIDTH-1:0] byte_nx;

  assign beat = tvalid & tready;

  always_comb begin
    keep_ext = '0;
    keep_ext[KEEP_WIDTH-1:0] = tkeep;
  end

  assign pop = popcount(keep_ext);

  // One extra MSB per adder: a carry out means the count would wrap.
  assign cyc_sum  = {1'b0, cycle_cnt} + (CNT_WIDTH+1)'(1);
  assign beat_sum = {1'b0, beat_cnt} + (CNT_WIDTH+1)'(1);
  assign pkt_sum  = {1'b0, pkt_cnt} + (CNT_WIDTH+1)'(1);
  assign byte_sum = {1'b0, byte_cnt} + (BYTE_CNT_WIDTH+1)'(pop);

  assign cyc_nx  = cyc_sum[CNT_WIDTH] ? cycle_cnt
                 : cyc_sum[CNT_WIDTH-1:0];
  assign beat_nx = beat_sum[CNT_WIDTH] ? beat_cnt
                 : beat_sum[CNT_WIDTH-1:0];
  assign pkt_nx  = pkt_sum[CNT_WIDTH] ? pkt_cnt
                 : pkt_sum[CNT_WIDTH-1:0];
  assign byte_nx = byte_sum[BYTE_CNT_WIDTH] ? '1
                 : byte_sum[BYTE_CNT_WIDTH-1:0];

  assign ovf = cyc_sum[CNT_WIDTH]
             | (beat & (beat_sum[CNT_WIDTH]
                        | byte_sum[BYTE_CNT_WIDTH]))
             | (beat & tlast & pkt_sum[CNT_WIDTH]);

  assign hit = (target != '0) & beat & tlast
             & (pkt_nx == target);

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    clr     = 1'b0;
    if (start) begin
      state_d = ST_ARMED;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ARMED: begin
          if (stop) begin
            state_d = ST_DONE;
          end else if (beat) begin
            cnt_en  = 1'b1;
            state_d = hit ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          cnt_en = 1'b1;
          if (stop || hit) state_d = ST_DONE;
        end
        ST_DONE: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cycle_cnt   <= '0;
      beat_cnt    <= '0;
      pkt_cnt     <= '0;
      byte_cnt    <= '0;
      first_frame <= 1'b0;
      overflow    <= 1'b0;
    end else if (clr) begin
      cycle_cnt   <= '0;
      beat_cnt    <= '0;
      pkt_cnt     <= '0;
      byte_cnt    <= '0;
      first_frame <= 1'b0;
      overflow    <= 1'b0;
    end else if (cnt_en) begin
      cycle_cnt <= cyc_nx;
      overflow  <= overflow | ovf;
      if (beat) begin
        beat_cnt    <= beat_nx;
        byte_cnt    <= byte_nx;
        first_frame <= 1'b1;
        if (tlast) pkt_cnt <= pkt_nx;
      end
    end
  end

  assign state = state_q;

endmodule

// File: rtl/axis_perf_monitor.sv
// axis_perf_monitor: passive multi-channel AXI-Stream monitor.
// Latches the packet target, fans start/stop to every channel,
// packs per-channel results and reduces all_done.
module axis_perf_monitor
  import axis_perf_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int KEEP_WIDTH     = DEF_KEEP_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int BYTE_CNT_WIDTH = DEF_BYTE_CNT_WIDTH
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic [NUM_CH-1:0]                mon_tvalid,
  input  logic [NUM_CH-1:0]                mon_tready,
  input  logic [NUM_CH-1:0]                mon_tlast,
  input  logic [NUM_CH*KEEP_WIDTH-1:0]     mon_tkeep,
  input  logic                             start,
  input  logic                             stop,
  input  logic [CNT_WIDTH-1:0]             target_pkt_num,
  output logic [NUM_CH*2-1:0]              ch_state,
  output logic [NUM_CH-1:0]                first_frame,
  output logic [NUM_CH*CNT_WIDTH-1:0]      cycle_cnt,
  output logic [NUM_CH*CNT_WIDTH-1:0]      beat_cnt,
  output logic [NUM_CH*CNT_WIDTH-1:0]      pkt_cnt,
  output logic [NUM_CH*BYTE_CNT_WIDTH-1:0] byte_cnt,
  output logic [NUM_CH-1:0]                overflow,
  output logic                             all_done
);

  logic [CNT_WIDTH-1:0] target_q;
  logic [NUM_CH-1:0]    done_vec;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     target_q <= '0;
    else if (start) target_q <= target_pkt_num;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    axis_perf_channel #(
      .KEEP_WIDTH     (KEEP_WIDTH),
      .CNT_WIDTH      (CNT_WIDTH),
      .BYTE_CNT_WIDTH (BYTE_CNT_WIDTH)
    ) u_ch (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .tvalid      (mon_tvalid[i]),
      .tready      (mon_tready[i]),
      .tlast       (mon_tlast[i]),
      .tkeep       (mon_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]),
      .start       (start),
      .stop        (stop),
      .target      (target_q),
      .state       (ch_state[2*i +: 2]),
      .first_frame (first_frame[i]),
      .cycle_cnt   (cycle_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .beat_cnt    (beat_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .pkt_cnt     (pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .byte_cnt    (byte_cnt[i*BYTE_CNT_WIDTH +: BYTE_CNT_WIDTH]),
      .overflow    (overflow[i])
    );
    assign done_vec[i] = (ch_state[2*i +: 2] == ST_DONE);
  end

  assign all_done = &done_vec;

endmodule

// File: tb/tb_axis_perf_monitor.sv
// tb_axis_perf_monitor: two-channel, 8-bit counter bench with a
// reference model, a scoreboard queue and a packet vector table.
module tb_axis_perf_monitor;

  localparam int NCH = 2;
  localparam int KW  = 64;
  localparam int CW  = 8;
  localparam int BW  = 40;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [NCH-1:0] mon_tvalid = '0;
  logic [NCH-1:0] mon_tready = '0;
  logic [NCH-1:0] mon_tlast = '0;
  logic [NCH*KW-1:0] mon_tkeep = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] target_pkt_num = '0;
  logic [NCH*2-1:0]  ch_state;
  logic [NCH-1:0]    first_frame;
  logic [NCH*CW-1:0] cycle_cnt, beat_cnt, pkt_cnt;
  logic [NCH*BW-1:0] byte_cnt;
  logic [NCH-1:0]    overflow;
  logic              all_done;

  axis_perf_monitor #(
    .NUM_CH(NCH), .KEEP_WIDTH(KW),
    .CNT_WIDTH(CW), .BYTE_CNT_WIDTH(BW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tlast(mon_tlast), .mon_tkeep(mon_tkeep),
    .start(start), .stop(stop),
    .target_pkt_num(target_pkt_num),
    .ch_state(ch_state), .first_frame(first_frame),
    .cycle_cnt(cycle_cnt), .beat_cnt(beat_cnt),
    .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt),
    .overflow(overflow), .all_done(all_done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]    st;
    logic [CW-1:0] cyc;
    logic [CW-1:0] bt;
    logic [CW-1:0] pk;
    logic [BW-1:0] by;
    logic          ff;
    logic          ov;
  } ch_snap_t;

  typedef struct packed {
    logic               ad;
    ch_snap_t [NCH-1:0] ch;
  } snap_t;

  typedef struct {
    logic          v;
    logic          l;
    logic [KW-1:0] k;
    logic          st;
    logic [CW-1:0] tgt;
    logic [CW-1:0] exp_beat;
    logic [CW-1:0] exp_pkt;
    logic [1:0]    exp_state;
  } vec_t;

  int checks = 0;
  int errors = 0;

  ch_snap_t [NCH-1:0] m;
  logic [CW-1:0] m_tgt;
  snap_t sb[$];

  localparam logic [BW-1:0] BMAX = {BW{1'b1}};

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.ch = m;
    s.ad = (m[0].st == 2'd3) && (m[1].st == 2'd3);
    return s;
  endfunction

  function automatic void cmp(snap_t e, string tag);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("%s ch%0d state", tag, c),
          64'(ch_state[2*c +: 2]), 64'(e.ch[c].st));
      chk($sformatf("%s ch%0d cycle", tag, c),
          64'(cycle_cnt[CW*c +: CW]), 64'(e.ch[c].cyc));
      chk($sformatf("%s ch%0d beat", tag, c),
          64'(beat_cnt[CW*c +: CW]), 64'(e.ch[c].bt));
      chk($sformatf("%s ch%0d pkt", tag, c),
          64'(pkt_cnt[CW*c +: CW]), 64'(e.ch[c].pk));
      chk($sformatf("%s ch%0d byte", tag, c),
          64'(byte_cnt[BW*c +: BW]), 64'(e.ch[c].by));
      chk($sformatf("%s ch%0d first_frame", tag, c),
          64'(first_frame[c]), 64'(e.ch[c].ff));
      chk($sformatf("%s ch%0d overflow", tag, c),
          64'(overflow[c]), 64'(e.ch[c].ov));
    end
    chk($sformatf("%s all_done", tag), 64'(all_done), 64'(e.ad));
  endfunction

  function automatic void model_reset();
    m = '0;
    m_tgt = '0;
  endfunction

  // Behavioural reference: what one clock edge does to each channel.
  function automatic void model_step(
    logic [1:0] v, logic [1:0] r, logic [1:0] l,
    logic [KW-1:0] k0, logic [KW-1:0] k1,
    logic st, logic sp, logic [CW-1:0] tgt);
    for (int c = 0; c < NCH; c++) begin
      logic b, hit;
      int p;
      b = v[c] & r[c];
      p = (c == 0) ? $countones(k0) : $countones(k1);
      hit = 1'b0;
      if (st) begin
        m[c] = '0;
        m[c].st = 2'd1;
      end else if (m[c].st == 2'd1 && sp) begin
        m[c].st = 2'd3;
      end else if ((m[c].st == 2'd1 && b) || m[c].st == 2'd2) begin
        if (m[c].cyc == 8'hFF) m[c].ov = 1'b1;
        else m[c].cyc = m[c].cyc + 8'd1;
        if (b) begin
          m[c].ff = 1'b1;
          if (m[c].bt == 8'hFF) m[c].ov = 1'b1;
          else m[c].bt = m[c].bt + 8'd1;
          if (BMAX - m[c].by < BW'(p)) begin
            m[c].by = BMAX;
            m[c].ov = 1'b1;
          end else begin
            m[c].by = m[c].by + BW'(p);
          end
          if (l[c]) begin
            if (m[c].pk == 8'hFF) m[c].ov = 1'b1;
            else m[c].pk = m[c].pk + 8'd1;
            hit = (m_tgt != 0) && (m[c].pk == m_tgt);
          end
        end
        m[c].st = (sp || hit) ? 2'd3 : 2'd2;
      end
    end
    if (st) m_tgt = tgt;
  endfunction

  task automatic step(
    input logic [1:0] v, input logic [1:0] r,
    input logic [1:0] l,
    input logic [KW-1:0] k0, input logic [KW-1:0] k1,
    input logic st, input logic sp,
    input logic [CW-1:0] tgt);
    snap_t e;
    @(negedge CLK);
    mon_tvalid = v;
    mon_tready = r;
    mon_tlast = l;
    mon_tkeep = {k1, k0};
    start = st;
    stop = sp;
    target_pkt_num = tgt;
    model_step(v, r, l, k0, k1, st, sp, tgt);
    sb.push_back(model_snap());
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    cmp(e, "sb");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(2'b00, 2'b00, 2'b00, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_start(input logic [CW-1:0] tgt);
    step(2'b00, 2'b00, 2'b00, '0, '0, 1'b1, 1'b0, tgt);
  endtask

  function automatic vec_t mk(logic v, logic l, logic [KW-1:0] k,
      logic st, logic [CW-1:0] tgt, int eb, int ep, int es);
    vec_t t;
    t.v = v; t.l = l; t.k = k; t.st = st; t.tgt = tgt;
    t.exp_beat = CW'(eb);
    t.exp_pkt = CW'(ep);
    t.exp_state = 2'(es);
    return t;
  endfunction

  vec_t tv[16];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [KW-1:0] ones;
    logic [KW-1:0] sparse;
    ones = '1;
    sparse = 64'h8001_0000_0000_00FF;

    // Target-stop table: start with target 4, four 3-beat
    // packets (full, full, 4 bytes), then a fifth that is ignored.
    tv[0] = mk(1'b0, 1'b0, '0, 1'b1, 8'd4, 0, 0, 1);
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 3; b++) begin
        int row;
        row = 1 + p * 3 + b;
        tv[row] = mk(1'b1, b == 2, (b == 2) ? 64'hF : ones,
                     1'b0, '0, p * 3 + b + 1, p + (b == 2 ? 1 : 0),
                     (row == 12) ? 3 : 2);
      end
    end
    for (int b = 0; b < 3; b++)
      tv[13 + b] = mk(1'b1, b == 2, ones, 1'b0, '0, 12, 4, 3);

    // Reset state and asynchronous mid-run reset.
    model_reset();
    #1;
    cmp(model_snap(), "reset");
    @(negedge CLK);
    RST_N = 1'b1;
    do_start(8'd0);
    step(2'b01, 2'b01, 2'b00, ones, '0, 1'b0, 1'b0, '0);
    step(2'b01, 2'b01, 2'b01, ones, '0, 1'b0, 1'b0, '0);
    chk("pre-reset beat", 64'(beat_cnt[CW-1:0]), 64'd2);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    cmp(model_snap(), "async reset");
    @(negedge CLK);
    RST_N = 1'b1;
    step(2'b01, 2'b01, 2'b01, ones, '0, 1'b0, 1'b0, '0);
    idle(2);

    // Target stop from the table.
    for (int i = 0; i < 16; i++) begin
      step({1'b0, tv[i].v}, 2'b01, {1'b0, tv[i].l},
           tv[i].k, '0, tv[i].st, 1'b0, tv[i].tgt);
      chk($sformatf("vec%0d beat", i),
          64'(beat_cnt[CW-1:0]), 64'(tv[i].exp_beat));
      chk($sformatf("vec%0d pkt", i),
          64'(pkt_cnt[CW-1:0]), 64'(tv[i].exp_pkt));
      chk($sformatf("vec%0d state", i),
          64'(ch_state[1:0]), 64'(tv[i].exp_state));
    end
    chk("target byte", 64'(byte_cnt[BW-1:0]), 64'd528);
    chk("target cycle", 64'(cycle_cnt[CW-1:0]), 64'd12);
    chk("target ch1 armed", 64'(ch_state[3:2]), 64'd1);
    chk("target all_done", 64'(all_done), 64'd0);

    // Backpressure, free-run, non-contiguous tkeep.
    do_start(8'd0);
    for (int i = 0; i < 20; i++)
      step(2'b01, {1'b0, i % 2 == 0}, 2'b00, sparse, '0,
           1'b0, 1'b0, '0);
    step(2'b00, 2'b00, 2'b00, '0, '0, 1'b0, 1'b1, '0);
    chk("bp beat", 64'(beat_cnt[CW-1:0]), 64'd10);
    chk("bp cycle", 64'(cycle_cnt[CW-1:0]), 64'd21);
    chk("bp byte", 64'(byte_cnt[BW-1:0]), 64'd100);
    chk("bp state", 64'(ch_state[1:0]), 64'd3);
    chk("bp ch1 beat", 64'(beat_cnt[2*CW-1:CW]), 64'd0);
    chk("bp all_done", 64'(all_done), 64'd1);

    // Saturation of 8-bit counters.
    do_start(8'd0);
    for (int i = 0; i < 300; i++)
      step(2'b01, 2'b01, 2'b00, 64'h1, '0, 1'b0, 1'b0, '0);
    chk("sat beat", 64'(beat_cnt[CW-1:0]), 64'd255);
    chk("sat cycle", 64'(cycle_cnt[CW-1:0]), 64'd255);
    chk("sat pkt", 64'(pkt_cnt[CW-1:0]), 64'd0);
    chk("sat byte", 64'(byte_cnt[BW-1:0]), 64'd300);
    chk("sat overflow", 64'(overflow[0]), 64'd1);

    // Restart from RUN; the beat in the start cycle is not counted.
    step(2'b01, 2'b01, 2'b01, ones, '0, 1'b1, 1'b0, 8'd0);
    chk("restart state", 64'(ch_state[1:0]), 64'd1);
    chk("restart beat", 64'(beat_cnt[CW-1:0]), 64'd0);
    chk("restart overflow", 64'(overflow[0]), 64'd0);
    chk("restart first_frame", 64'(first_frame[0]), 64'd0);
    step(2'b01, 2'b01, 2'b00, 64'hFF, '0, 1'b0, 1'b0, '0);
    chk("armed beat cycle", 64'(cycle_cnt[CW-1:0]), 64'd1);
    chk("armed beat byte", 64'(byte_cnt[BW-1:0]), 64'd8);

    // Multi-channel completion, ch1 five cycles after ch0.
    do_start(8'd2);
    step(2'b11, 2'b11, 2'b11, 64'hF, 64'hF, 1'b0, 1'b0, '0);
    step(2'b01, 2'b01, 2'b01, 64'hF, '0, 1'b0, 1'b0, '0);
    chk("mc ch0 done", 64'(ch_state[1:0]), 64'd3);
    chk("mc early all_done", 64'(all_done), 64'd0);
    idle(4);
    chk("mc late all_done low", 64'(all_done), 64'd0);
    step(2'b10, 2'b10, 2'b10, '0, 64'hF, 1'b0, 1'b0, '0);
    chk("mc ch1 done", 64'(ch_state[3:2]), 64'd3);
    chk("mc all_done", 64'(all_done), 64'd1);
    chk("mc ch1 cycle", 64'(cycle_cnt[2*CW-1:CW]), 64'd7);

    // Start and stop together: start wins.
    step(2'b00, 2'b00, 2'b00, '0, '0, 1'b1, 1'b1, 8'd0);
    chk("start+stop ch0", 64'(ch_state[1:0]), 64'd1);
    chk("start+stop ch1", 64'(ch_state[3:2]), 64'd1);
    chk("start+stop pkt", 64'(pkt_cnt), 64'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
